// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Memory responder for CPU rd/wr requests, with programmable
//               wait states, a one-cycle ready pulse and a host preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_add,
    input  logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] mem_dout,
    output logic              mem_ready,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_drop,
    output logic              proto_err
);

    localparam int         c_depth   = 2**ADDR_W;
    localparam logic [3:0] c_rd_wait = 4'(RD_WAIT);
    localparam logic [3:0] c_wr_wait = 4'(WR_WAIT);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [DATA_W-1:0] r_mem [c_depth];

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_is_wr;
    logic [DATA_W-1:0] r_dout;
    logic              r_drop;
    logic              r_perr;

    logic              w_accept;
    logic              w_acc_is_wr;
    logic [3:0]        w_acc_wait;
    logic              w_enter_resp;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_op_din;
    logic              w_op_is_wr;
    logic              w_ld_we;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_data;

    always_comb begin
        w_ld_we      = (r_state == c_idle) && ld_wr;
        w_accept     = (r_state == c_idle) && !ld_wr && (mem_rd || mem_wr);
        // Simultaneous rd and wr resolves to a read.
        w_acc_is_wr  = mem_wr && !mem_rd;
        w_acc_wait   = w_acc_is_wr ? c_wr_wait : c_rd_wait;

        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_next_state = (w_acc_wait != 4'd0) ? c_wait : c_resp;
                end
            end
            c_wait: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = c_resp;
                end
            end
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase

        // With zero wait states the access happens on the acceptance edge,
        // so the live request inputs are used instead of the latched copies.
        w_enter_resp = (w_next_state == c_resp) && (r_state != c_resp);
        w_op_addr    = (r_state == c_idle) ? mem_add     : r_addr;
        w_op_din     = (r_state == c_idle) ? mem_din     : r_din;
        w_op_is_wr   = (r_state == c_idle) ? w_acc_is_wr : r_is_wr;

        w_arr_we     = w_ld_we || (w_enter_resp && w_op_is_wr);
        w_arr_addr   = w_ld_we ? ld_addr : w_op_addr;
        w_arr_data   = w_ld_we ? ld_data : w_op_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_din   <= '0;
            r_is_wr <= 1'b0;
            r_dout  <= '0;
            r_drop  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt   <= w_acc_wait;
                r_addr  <= mem_add;
                r_din   <= mem_din;
                r_is_wr <= w_acc_is_wr;
            end else if (r_state == c_wait) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && !w_op_is_wr) begin
                r_dout <= r_mem[w_op_addr];
            end
            r_drop <= ld_wr && (r_state != c_idle);
            if (w_accept && mem_rd && mem_wr) begin
                r_perr <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; reset only kills the control path.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_mem[w_arr_addr] <= w_arr_data;
        end
    end

    assign mem_dout  = r_dout;
    assign mem_ready = (r_state == c_resp);
    assign ld_drop   = r_drop;
    assign proto_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Self-checking bench for cpu_mem_responder (vector table,
//               randomized ops against an array model, corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic       clk = 1'b0;
    logic       rst, mem_rd, mem_wr, ld_wr;
    logic [4:0] mem_add, ld_addr;
    logic [7:0] mem_din, ld_data;
    logic [7:0] mem_dout;
    logic       mem_ready, ld_drop, proto_err;

    logic       b_rst, b_mem_rd, b_mem_wr, b_ld_wr;
    logic [4:0] b_mem_add, b_ld_addr;
    logic [7:0] b_mem_din, b_ld_data;
    logic [7:0] b_mem_dout;
    logic       b_mem_ready, b_ld_drop, b_proto_err;

    always #5 clk = ~clk;

    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(1), .WR_WAIT(0)) u_dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .ld_wr(ld_wr), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_drop(ld_drop), .proto_err(proto_err)
    );

    // Second instance with write wait states, for the abort-on-reset case.
    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(2), .WR_WAIT(3)) u_dut_b (
        .clk(clk), .rst(b_rst), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
        .mem_add(b_mem_add), .mem_din(b_mem_din), .mem_dout(b_mem_dout),
        .mem_ready(b_mem_ready), .ld_wr(b_ld_wr), .ld_addr(b_ld_addr),
        .ld_data(b_ld_data), .ld_drop(b_ld_drop), .proto_err(b_proto_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [32];
    logic [7:0] last_dout;

    typedef struct {
        int         op;     // 0 load, 1 write, 2 read
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp;    // expected mem_dout after the operation
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [4:0] a, input logic [7:0] d);
        ld_wr = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_wr = 1'b0;
        model[a] = d;
        check("ld_drop_idle", ld_drop, 0);
    endtask

    // Issues one CPU transaction starting in IDLE; returns with DUT in IDLE.
    task automatic do_txn(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [7:0] d, input int exp_w, output logic [7:0] dout);
        int n;
        mem_rd = rd; mem_wr = wr; mem_add = a; mem_din = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_ready && n < 40);
        mem_rd = 1'b0; mem_wr = 1'b0;
        check("latency", n, exp_w + 1);
        dout = mem_dout;
        @(posedge clk); #1;
        check("ready_one_cycle", mem_ready, 0);
    endtask

    task automatic b_read(input logic [4:0] a, output int n, output logic [7:0] d);
        b_mem_rd = 1'b1; b_mem_add = a;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!b_mem_ready && n < 40);
        b_mem_rd = 1'b0;
        d = b_mem_dout;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] v;
        logic [4:0] a;
        int         n, op, pulses, first_p, second_p;

        tbl[0] = '{0, 5'd5,  8'hA7, 8'h00};
        tbl[1] = '{2, 5'd5,  8'h00, 8'hA7};
        tbl[2] = '{1, 5'd31, 8'h3C, 8'hA7};
        tbl[3] = '{2, 5'd31, 8'h00, 8'h3C};
        tbl[4] = '{0, 5'd0,  8'h11, 8'h00};
        tbl[5] = '{2, 5'd0,  8'h00, 8'h11};
        tbl[6] = '{1, 5'd7,  8'h5A, 8'h11};
        tbl[7] = '{1, 5'd7,  8'h5B, 8'h11};
        tbl[8] = '{2, 5'd7,  8'h00, 8'h5B};
        tbl[9] = '{2, 5'd5,  8'h00, 8'hA7};

        rst = 1'b1; mem_rd = 0; mem_wr = 0; mem_add = 0; mem_din = 0;
        ld_wr = 0; ld_addr = 0; ld_data = 0;
        b_rst = 1'b1; b_mem_rd = 0; b_mem_wr = 0; b_mem_add = 0; b_mem_din = 0;
        b_ld_wr = 0; b_ld_addr = 0; b_ld_data = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;
        check("rst_dout", mem_dout, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_drop", ld_drop, 0);
        check("rst_perr", proto_err, 0);

        // Reset in the middle of a write's wait states leaves the array alone.
        b_ld_wr = 1'b1; b_ld_addr = 5'd3; b_ld_data = 8'h55;
        @(posedge clk); #1;
        b_ld_wr = 1'b0;
        b_read(5'd3, n, d);
        check("b_rd_latency", n, 3);
        check("b_rd_data", d, 8'h55);
        b_mem_wr = 1'b1; b_mem_add = 5'd3; b_mem_din = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        check("b_wait_no_ready", b_mem_ready, 0);
        b_rst = 1'b1;
        #1;
        check("b_rst_dout", b_mem_dout, 0);
        check("b_rst_ready", b_mem_ready, 0);
        b_mem_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_read(5'd3, n, d);
        check("b_abort_kept", d, 8'h55);

        for (int i = 0; i < 32; i++) do_load(5'(i), 8'($urandom));
        last_dout = mem_dout;

        for (int i = 0; i < 10; i++) begin
            case (tbl[i].op)
                0: do_load(tbl[i].addr, tbl[i].data);
                1: begin
                    do_txn(1'b0, 1'b1, tbl[i].addr, tbl[i].data, 0, d);
                    model[tbl[i].addr] = tbl[i].data;
                    check("tbl_wr_dout", d, tbl[i].exp);
                end
                default: begin
                    do_txn(1'b1, 1'b0, tbl[i].addr, 8'h00, 1, d);
                    check("tbl_rd_dout", d, tbl[i].exp);
                end
            endcase
        end
        last_dout = 8'hA7;

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            a  = 5'($urandom);
            v  = 8'($urandom);
            if (op == 0) begin
                do_load(a, v);
            end else if (op == 1) begin
                do_txn(1'b0, 1'b1, a, v, 0, d);
                model[a] = v;
                check("rnd_wr_dout_hold", d, last_dout);
            end else begin
                do_txn(1'b1, 1'b0, a, 8'h00, 1, d);
                check("rnd_rd_dout", d, model[a]);
                last_dout = model[a];
            end
        end
        check("perr_clean", proto_err, 0);

        // rd and wr together: completes as a read, flags sticky error.
        do_txn(1'b1, 1'b1, 5'd2, 8'hFF, 1, d);
        check("both_rd_data", d, model[2]);
        check("both_perr", proto_err, 1);
        do_txn(1'b1, 1'b0, 5'd4, 8'h00, 1, d);
        check("perr_sticky", proto_err, 1);

        // Load strobe during WAIT is dropped.
        mem_rd = 1'b1; mem_add = 5'd12;
        @(posedge clk); #1;
        ld_wr = 1'b1; ld_addr = 5'd12; ld_data = ~model[12];
        @(posedge clk); #1;
        check("drop_ready", mem_ready, 1);
        check("drop_pulse", ld_drop, 1);
        mem_rd = 1'b0; ld_wr = 1'b0;
        @(posedge clk); #1;
        check("drop_one_cycle", ld_drop, 0);
        do_txn(1'b1, 1'b0, 5'd12, 8'h00, 1, d);
        check("drop_array_kept", d, model[12]);

        // Request held one cycle past ready starts a second transaction.
        mem_rd = 1'b1; mem_add = 5'd9;
        pulses = 0; first_p = 0; second_p = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                pulses++;
                if (pulses == 1) first_p = k;
                else second_p = k;
            end
            if (k == 4) mem_rd = 1'b0;
        end
        check("held_pulses", pulses, 2);
        check("held_first", first_p, 2);
        check("held_spacing", second_p - first_p, 3);

        // Reset clears outputs but not contents.
        rst = 1'b1;
        #2;
        check("rst2_dout", mem_dout, 0);
        check("rst2_perr", proto_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(1'b1, 1'b0, 5'd7, 8'h00, 1, d);
        check("rst2_array_kept", d, model[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
